// File: rtl/control_unit.sv
// Main decoder for the single-cycle MIPS-style datapath, plus a legal-instruction counter.
// Optional illegal-opcode tracking is enabled by defining CTRL_ILLEGAL_TRAP_EN.
module control_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  opcode,
   output logic [1:0]  RegDst,
   output logic        Jump,
   output logic        Branch,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        ALUSrc,
   output logic        RegWrite,
   output logic        jr_control,
   output logic [1:0]  MemtoReg,
   output logic [1:0]  ALUOp,
   output logic        illegal,
   output logic        illegal_sticky,
   output logic [31:0] insn_count
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_BLE   = 6'h06;
   localparam logic [5:0] OP_BGT   = 6'h07;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_JR    = 6'h11;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   logic legal;

   // Unknown opcodes fall through with every enable at 0, i.e. a NOP.
   always_comb begin
      RegDst     = 2'b00;
      Jump       = 1'b0;
      Branch     = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      ALUSrc     = 1'b0;
      RegWrite   = 1'b0;
      jr_control = 1'b0;
      MemtoReg   = 2'b00;
      ALUOp      = 2'b00;
      legal      = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            RegDst   = 2'b01;
            RegWrite = 1'b1;
            ALUOp    = 2'b10;
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI: begin
            ALUSrc   = 1'b1;
            RegWrite = 1'b1;
            ALUOp    = 2'b11;
         end
         OP_LW: begin
            ALUSrc   = 1'b1;
            MemRead  = 1'b1;
            MemtoReg = 2'b01;
            RegWrite = 1'b1;
         end
         OP_SW: begin
            ALUSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         OP_BEQ, OP_BNE, OP_BLE, OP_BGT: begin
            Branch = 1'b1;
            ALUOp  = 2'b01;
         end
         OP_J:    Jump = 1'b1;
         OP_JAL: begin
            Jump     = 1'b1;
            RegWrite = 1'b1;
            RegDst   = 2'b10;
            MemtoReg = 2'b10;
         end
         OP_JR:   jr_control = 1'b1;
         default: legal = 1'b0;
      endcase
      // Reset masks the datapath regardless of opcode.
      if (rst) begin
         RegDst     = 2'b00;
         Jump       = 1'b0;
         Branch     = 1'b0;
         MemRead    = 1'b0;
         MemWrite   = 1'b0;
         ALUSrc     = 1'b0;
         RegWrite   = 1'b0;
         jr_control = 1'b0;
         MemtoReg   = 2'b00;
         ALUOp      = 2'b00;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         insn_count <= 32'd0;
      else if (legal)
         insn_count <= insn_count + 32'd1;
   end

`ifdef CTRL_ILLEGAL_TRAP_EN
   assign illegal = ~rst & ~legal;

   always_ff @(posedge clk) begin
      if (rst)
         illegal_sticky <= 1'b0;
      else if (illegal)
         illegal_sticky <= 1'b1;
   end
`else
   assign illegal        = 1'b0;
   assign illegal_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; expectations follow CTRL_ILLEGAL_TRAP_EN.
module tb_control_unit;

   logic        clk;
   logic        rst;
   logic [5:0]  opcode;
   logic [1:0]  RegDst;
   logic        Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite, jr_control;
   logic [1:0]  MemtoReg;
   logic [1:0]  ALUOp;
   logic        illegal;
   logic        illegal_sticky;
   logic [31:0] insn_count;

   int pass_cnt = 0;
   int total_cnt = 0;

`ifdef CTRL_ILLEGAL_TRAP_EN
   localparam logic TRAP = 1'b1;
`else
   localparam logic TRAP = 1'b0;
`endif

   control_unit dut (
      .clk(clk), .rst(rst), .opcode(opcode),
      .RegDst(RegDst), .Jump(Jump), .Branch(Branch), .MemRead(MemRead),
      .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
      .jr_control(jr_control), .MemtoReg(MemtoReg), .ALUOp(ALUOp),
      .illegal(illegal), .illegal_sticky(illegal_sticky), .insn_count(insn_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {RegDst, Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite, jr_control, MemtoReg, ALUOp}
   logic [12:0] outs;
   assign outs = {RegDst, Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite,
                  jr_control, MemtoReg, ALUOp};

   logic [5:0]  sweep_op  [15];
   logic [12:0] sweep_exp [15];

   initial begin
      sweep_op[0]  = 6'h00; sweep_exp[0]  = 13'b01_0_0_0_0_0_1_0_00_10;
      sweep_op[1]  = 6'h08; sweep_exp[1]  = 13'b00_0_0_0_0_1_1_0_00_11;
      sweep_op[2]  = 6'h09; sweep_exp[2]  = 13'b00_0_0_0_0_1_1_0_00_11;
      sweep_op[3]  = 6'h0A; sweep_exp[3]  = 13'b00_0_0_0_0_1_1_0_00_11;
      sweep_op[4]  = 6'h0C; sweep_exp[4]  = 13'b00_0_0_0_0_1_1_0_00_11;
      sweep_op[5]  = 6'h0D; sweep_exp[5]  = 13'b00_0_0_0_0_1_1_0_00_11;
      sweep_op[6]  = 6'h23; sweep_exp[6]  = 13'b00_0_0_1_0_1_1_0_01_00;
      sweep_op[7]  = 6'h2B; sweep_exp[7]  = 13'b00_0_0_0_1_1_0_0_00_00;
      sweep_op[8]  = 6'h04; sweep_exp[8]  = 13'b00_0_1_0_0_0_0_0_00_01;
      sweep_op[9]  = 6'h05; sweep_exp[9]  = 13'b00_0_1_0_0_0_0_0_00_01;
      sweep_op[10] = 6'h06; sweep_exp[10] = 13'b00_0_1_0_0_0_0_0_00_01;
      sweep_op[11] = 6'h07; sweep_exp[11] = 13'b00_0_1_0_0_0_0_0_00_01;
      sweep_op[12] = 6'h02; sweep_exp[12] = 13'b00_1_0_0_0_0_0_0_00_00;
      sweep_op[13] = 6'h03; sweep_exp[13] = 13'b10_1_0_0_0_0_1_0_10_00;
      sweep_op[14] = 6'h11; sweep_exp[14] = 13'b00_0_0_0_0_0_0_1_00_00;
   end

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1; opcode = 6'h23;
      #1;
      total_cnt++;
      if (outs !== 13'd0) $display("FAIL reset_outs: got %b want %b", outs, 13'd0);
      else pass_cnt++;
      total_cnt++;
      if (illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", illegal);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (insn_count !== 32'd0) $display("FAIL reset_count: got %h want 0", insn_count);
      else pass_cnt++;
      total_cnt++;
      if (illegal_sticky !== 1'b0) $display("FAIL reset_sticky: got %b want 0", illegal_sticky);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_sweep;
      for (int i = 0; i < 15; i++) begin
         opcode = sweep_op[i];
         #1;
         total_cnt++;
         if (outs !== sweep_exp[i] || illegal !== 1'b0)
            $display("FAIL sweep_op%02h: got %b ill=%b want %b ill=0",
                     sweep_op[i], outs, illegal, sweep_exp[i]);
         else pass_cnt++;
         @(negedge clk);
      end
      total_cnt++;
      if (insn_count !== 32'd15) $display("FAIL sweep_count: got %0d want 15", insn_count);
      else pass_cnt++;
   endtask

   task automatic test_illegal;
      opcode = 6'h3F;
      #1;
      total_cnt++;
      if (outs !== 13'd0) $display("FAIL illegal_outs: got %b want 0", outs);
      else pass_cnt++;
      total_cnt++;
      if (illegal !== TRAP) $display("FAIL illegal_flag: got %b want %b", illegal, TRAP);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (illegal_sticky !== TRAP) $display("FAIL illegal_sticky_set: got %b want %b", illegal_sticky, TRAP);
      else pass_cnt++;
      total_cnt++;
      if (insn_count !== 32'd15) $display("FAIL illegal_no_count: got %0d want 15", insn_count);
      else pass_cnt++;
      opcode = 6'h00;
      #1;
      total_cnt++;
      if (illegal !== 1'b0) $display("FAIL illegal_clear: got %b want 0", illegal);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (illegal_sticky !== TRAP) $display("FAIL illegal_sticky_hold: got %b want %b", illegal_sticky, TRAP);
      else pass_cnt++;
      total_cnt++;
      if (insn_count !== 32'd16) $display("FAIL illegal_then_legal_count: got %0d want 16", insn_count);
      else pass_cnt++;
   endtask

   task automatic test_wrap;
      dut.insn_count = 32'hFFFF_FFFF;
      opcode = 6'h00;
      @(negedge clk);
      total_cnt++;
      if (insn_count !== 32'h0000_0000) $display("FAIL wrap_count: got %h want 00000000", insn_count);
      else pass_cnt++;
   endtask

   task automatic test_jal;
      opcode = 6'h03;
      #1;
      total_cnt++;
      if (outs !== 13'b10_1_0_0_0_0_1_0_10_00 || illegal !== 1'b0)
         $display("FAIL jal_outs: got %b ill=%b want %b ill=0", outs, illegal, 13'b10_1_0_0_0_0_1_0_10_00);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (insn_count !== 32'd1) $display("FAIL jal_count: got %0d want 1", insn_count);
      else pass_cnt++;
   endtask

   task automatic test_reset_priority;
      rst = 1'b1; opcode = 6'h3F;
      #1;
      total_cnt++;
      if (outs !== 13'd0 || illegal !== 1'b0)
         $display("FAIL rstprio_comb: got %b ill=%b want 0 ill=0", outs, illegal);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (illegal_sticky !== 1'b0) $display("FAIL rstprio_sticky: got %b want 0", illegal_sticky);
      else pass_cnt++;
      total_cnt++;
      if (insn_count !== 32'd0) $display("FAIL rstprio_count: got %0d want 0", insn_count);
      else pass_cnt++;
      rst = 1'b0; opcode = 6'h2B;
      @(negedge clk);
      total_cnt++;
      if (insn_count !== 32'd1) $display("FAIL post_reset_count: got %0d want 1", insn_count);
      else pass_cnt++;
   endtask

   initial begin
      rst = 1'b1;
      opcode = 6'h00;
      test_reset;
      test_sweep;
      test_illegal;
      test_wrap;
      test_jal;
      test_reset_priority;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
